// File: rtl/piano_pkg.sv
// Shared types and constants for the electric piano note path: FSM encoding,
// default tune table and the triangle-wave shaper.
package piano_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPlay    = 2'd1,
      StRelease = 2'd2
   } note_state_e;

   localparam int unsigned ENV_MAX      = 15;
   localparam int unsigned TUNE_ENTRIES = 8;

   // C4..C5 phase increments per frame at CP = 50 MHz, Fs = CP/256; entry 0 is last.
   localparam logic [TUNE_ENTRIES-1:0][15:0] TUNE_DEFAULT = {
      16'd176, 16'd166, 16'd148, 16'd132, 16'd117, 16'd111, 16'd99, 16'd88
   };

   // Takes the top 8 phase bits; rising half then mirrored falling half.
   function automatic logic [7:0] tri_wave(input logic [7:0] hi);
      return hi[7] ? ~{hi[6:0], 1'b0} : {hi[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/key_priority_arb.sv
// Combinational key arbiter: highest-index pressed key wins.
module key_priority_arb #(
   parameter int unsigned NKEYS = 8
) (
   input  logic [NKEYS-1:0] keys,
   output logic [2:0]       winner,
   output logic             any
);

   always_comb begin
      winner = '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
         if (keys[i]) winner = 3'(i);
      end
   end

   assign any = |keys;

endmodule

// File: rtl/pwm_note_scheduler.sv
// Picks one sounding note from the key bank and produces a per-frame duty word
// from a phase accumulator, triangle shaper and attack/release envelope.
module pwm_note_scheduler
   import piano_pkg::*;
#(
   parameter int unsigned NKEYS      = 8,
   parameter int unsigned FRAME_BITS = 8,
   parameter int unsigned PHASE_BITS = 16,
   parameter int unsigned ENV_BITS   = 4
) (
   input  logic                  CP,
   input  logic                  RST,
   input  logic [NKEYS-1:0]      key_in,
   input  logic                  tune_wr_en,
   input  logic [2:0]            tune_wr_addr,
   input  logic [PHASE_BITS-1:0] tune_wr_data,
   output logic [7:0]            musicdata,
   output logic                  frame_tick,
   output logic                  note_valid,
   output logic [2:0]            active_key
);

   logic [FRAME_BITS-1:0]   frame_q;
   logic [PHASE_BITS-1:0]   tune_q [TUNE_ENTRIES];
   note_state_e             state_q, state_d;
   logic [PHASE_BITS-1:0]   phase_q, phase_d, step;
   logic [ENV_BITS-1:0]     env_q, env_d;
   logic [2:0]              key_q, key_d;
   logic [7:0]              music_q, music_d;
   logic [7:0]              tri_v;
   logic [7+ENV_BITS:0]     product;
   logic [TUNE_ENTRIES-1:0] addr_ok;
   logic                    wr_ok;
   logic                    any;
   logic [2:0]              winner;

   key_priority_arb #(
      .NKEYS(NKEYS)
   ) u_arb (
      .keys  (key_in),
      .winner(winner),
      .any   (any)
   );

   assign frame_tick = (frame_q == '1);
   assign note_valid = (state_q != StIdle);
   assign musicdata  = music_q;
   assign active_key = key_q;

   always_comb begin
      for (int unsigned i = 0; i < TUNE_ENTRIES; i++) addr_ok[i] = (i < NKEYS);
   end
   assign wr_ok = tune_wr_en && addr_ok[tune_wr_addr];

   always_ff @(posedge CP) begin
      if (RST) frame_q <= '0;
      else     frame_q <= frame_q + FRAME_BITS'(1);
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         for (int unsigned i = 0; i < TUNE_ENTRIES; i++) begin
            tune_q[i] <= PHASE_BITS'(TUNE_DEFAULT[i]);
         end
      end else if (wr_ok) begin
         tune_q[tune_wr_addr] <= tune_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      env_d   = env_q;
      key_d   = key_q;
      music_d = music_q;
      step    = '0;
      tri_v   = tri_wave(phase_q[PHASE_BITS-1 -: 8]);
      product = {{ENV_BITS{1'b0}}, tri_v} * {8'd0, env_q};

      if (frame_tick) begin
         music_d = (state_q == StIdle) ? 8'd0 : 8'(product >> ENV_BITS);

         unique case (state_q)
            StIdle: begin
               if (any) begin
                  state_d = StPlay;
                  key_d   = winner;
                  env_d   = ENV_BITS'(1);
               end
            end
            StPlay: begin
               if (any) begin
                  key_d = winner;
                  if (env_q != ENV_BITS'(ENV_MAX)) env_d = env_q + ENV_BITS'(1);
               end else begin
                  state_d = StRelease;
               end
            end
            StRelease: begin
               if (any) begin
                  state_d = StPlay;
                  key_d   = winner;
                  if (env_q != ENV_BITS'(ENV_MAX)) env_d = env_q + ENV_BITS'(1);
               end else if (env_q <= ENV_BITS'(1)) begin
                  state_d = StIdle;
                  env_d   = '0;
               end else begin
                  env_d = env_q - ENV_BITS'(1);
               end
            end
            default: state_d = StIdle;
         endcase

         // A tune write landing on the tick cycle must already steer this step.
         step    = (wr_ok && tune_wr_addr == key_d) ? tune_wr_data : tune_q[key_d];
         phase_d = (state_q == StIdle || state_d == StIdle) ? '0 : phase_q + step;
      end
   end

   always_ff @(posedge CP) begin
      if (RST) begin
         state_q <= StIdle;
         phase_q <= '0;
         env_q   <= '0;
         key_q   <= '0;
         music_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         env_q   <= env_d;
         key_q   <= key_d;
         music_q <= music_d;
      end
   end

endmodule

// File: tb/tb_pwm_note_scheduler.sv
// Directed bench for pwm_note_scheduler; expected duty words are hand-computed
// as (tri(phase) * env) >> 4 per frame tick.
module tb_pwm_note_scheduler;

   logic        CP;
   logic        RST;
   logic [7:0]  key_in;
   logic        tune_wr_en;
   logic [2:0]  tune_wr_addr;
   logic [15:0] tune_wr_data;
   logic [7:0]  musicdata;
   logic        frame_tick;
   logic        note_valid;
   logic [2:0]  active_key;

   int n_cmp = 0;
   int n_err = 0;

   pwm_note_scheduler dut (
      .CP          (CP),
      .RST         (RST),
      .key_in      (key_in),
      .tune_wr_en  (tune_wr_en),
      .tune_wr_addr(tune_wr_addr),
      .tune_wr_data(tune_wr_data),
      .musicdata   (musicdata),
      .frame_tick  (frame_tick),
      .note_valid  (note_valid),
      .active_key  (active_key)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   // Advance through the next frame tick edge; outputs are sampled 1 time unit after it.
   task automatic wait_tick();
      int n = 0;
      @(negedge CP);
      while (!frame_tick && n < 300) begin
         @(negedge CP);
         n++;
      end
      if (!frame_tick) begin
         n_cmp++;
         n_err++;
         $display("FAIL tick_timeout: got no frame_tick after %0d cycles, want <= 256", n);
      end
      @(posedge CP);
      #1;
   endtask

   task automatic test_reset();
      int n = 0;
      RST = 1'b1;
      key_in = '0;
      tune_wr_en = 1'b0;
      tune_wr_addr = '0;
      tune_wr_data = '0;
      repeat (3) @(posedge CP);
      #1 RST = 1'b0;
      n_cmp++;
      if (musicdata !== 8'd0 || note_valid !== 1'b0 || active_key !== 3'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got md=%0d nv=%b ak=%0d, want 0/0/0",
                  musicdata, note_valid, active_key);
      end
      repeat (100) @(posedge CP);
      #1 RST = 1'b1;
      repeat (3) @(posedge CP);
      #1 RST = 1'b0;
      n_cmp++;
      if (frame_tick !== 1'b0 || musicdata !== 8'd0 || note_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midframe_reset: got ft=%b md=%0d nv=%b, want 0/0/0",
                  frame_tick, musicdata, note_valid);
      end
      @(negedge CP);
      while (!frame_tick && n < 300) begin
         @(posedge CP);
         n++;
         @(negedge CP);
      end
      n_cmp++;
      if (n + 1 != 256) begin
         n_err++;
         $display("FAIL first_tick_cycle: got edge %0d, want 256", n + 1);
      end
      @(posedge CP);
      #1;
      n_cmp++;
      if (frame_tick !== 1'b0) begin
         n_err++;
         $display("FAIL tick_width: got frame_tick=%b after tick edge, want 0", frame_tick);
      end
   endtask

   // Default tune 88 on key 0: pre-tick phase 88*(n-1), env min(n,15).
   task automatic test_attack();
      logic [7:0] exp_md [18];
      exp_md = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 3, 4, 4, 6, 7, 7, 9, 9, 9};
      key_in = 8'h01;
      wait_tick();
      n_cmp++;
      if (note_valid !== 1'b1 || musicdata !== 8'd0 || active_key !== 3'd0) begin
         n_err++;
         $display("FAIL attack_start: got nv=%b md=%0d ak=%0d, want 1/0/0",
                  note_valid, musicdata, active_key);
      end
      for (int i = 0; i < 18; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_md[i] || note_valid !== 1'b1) begin
            n_err++;
            $display("FAIL attack_md[%0d]: got md=%0d nv=%b, want md=%0d nv=1",
                     i + 1, musicdata, note_valid, exp_md[i]);
         end
      end
   endtask

   task automatic test_retarget();
      key_in = 8'h05;
      wait_tick();
      n_cmp++;
      if (active_key !== 3'd2 || musicdata !== 8'd11) begin
         n_err++;
         $display("FAIL retarget_up: got ak=%0d md=%0d, want ak=2 md=11", active_key, musicdata);
      end
      key_in = 8'h01;
      wait_tick();
      n_cmp++;
      if (active_key !== 3'd0 || musicdata !== 8'd11) begin
         n_err++;
         $display("FAIL retarget_down: got ak=%0d md=%0d, want ak=0 md=11", active_key, musicdata);
      end
      wait_tick();
      n_cmp++;
      if (musicdata !== 8'd11) begin
         n_err++;
         $display("FAIL retarget_phase: got md=%0d, want 11", musicdata);
      end
      key_in = 8'h81;
      wait_tick();
      n_cmp++;
      if (active_key !== 3'd7 || musicdata !== 8'd13) begin
         n_err++;
         $display("FAIL retarget_top: got ak=%0d md=%0d, want ak=7 md=13", active_key, musicdata);
      end
   endtask

   task automatic test_reset_mid_note();
      @(negedge CP);
      RST = 1'b1;
      key_in = '0;
      @(posedge CP);
      #1 RST = 1'b0;
      n_cmp++;
      if (musicdata !== 8'd0 || note_valid !== 1'b0 || active_key !== 3'd0) begin
         n_err++;
         $display("FAIL reset_mid_note: got md=%0d nv=%b ak=%0d, want 0/0/0",
                  musicdata, note_valid, active_key);
      end
   endtask

   // Key 0 retuned to 0x8000: phase alternates 0/0x8000, tri 0/255.
   task automatic test_tune_write();
      logic [7:0] exp_a [8];
      logic [7:0] exp_b [7];
      int n = 0;
      exp_a = '{0, 31, 0, 63, 0, 95, 0, 127};
      exp_b = '{80, 175, 95, 0, 112, 239, 119};
      key_in = 8'h01;
      wait_tick();
      @(negedge CP);
      tune_wr_en = 1'b1;
      tune_wr_addr = 3'd0;
      tune_wr_data = 16'h8000;
      @(negedge CP);
      tune_wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_a[i]) begin
            n_err++;
            $display("FAIL tune_alt[%0d]: got md=%0d, want %0d", i + 1, musicdata, exp_a[i]);
         end
         // 9 does not fit the 3-bit address; a write to another entry must not disturb key 0.
         if (i == 1) begin
            @(negedge CP);
            tune_wr_en = 1'b1;
            tune_wr_addr = 3'd1;
            tune_wr_data = 16'h1234;
            @(negedge CP);
            tune_wr_en = 1'b0;
         end
      end
      @(negedge CP);
      while (!frame_tick && n < 300) begin
         @(negedge CP);
         n++;
      end
      tune_wr_en = 1'b1;
      tune_wr_addr = 3'd0;
      tune_wr_data = 16'h4000;
      @(posedge CP);
      #1 tune_wr_en = 1'b0;
      n_cmp++;
      if (musicdata !== 8'd0 || frame_tick !== 1'b0) begin
         n_err++;
         $display("FAIL tune_same_cycle: got md=%0d ft=%b, want md=0 ft=0", musicdata, frame_tick);
      end
      for (int i = 0; i < 7; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_b[i]) begin
            n_err++;
            $display("FAIL tune_quarter[%0d]: got md=%0d, want %0d", i + 10, musicdata, exp_b[i]);
         end
      end
   endtask

   // Release from env 15 down to env 6, then re-press key 0.
   task automatic test_repress();
      logic [7:0] exp_rel [10];
      logic [7:0] exp_pl [4];
      exp_rel = '{0, 120, 223, 103, 0, 88, 159, 71, 0, 56};
      exp_pl  = '{95, 55, 0, 72};
      key_in = 8'h00;
      for (int i = 0; i < 10; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_rel[i] || note_valid !== 1'b1) begin
            n_err++;
            $display("FAIL repress_rel[%0d]: got md=%0d nv=%b, want md=%0d nv=1",
                     i, musicdata, note_valid, exp_rel[i]);
         end
      end
      key_in = 8'h01;
      for (int i = 0; i < 4; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_pl[i] || note_valid !== 1'b1) begin
            n_err++;
            $display("FAIL repress_play[%0d]: got md=%0d nv=%b, want md=%0d nv=1",
                     i, musicdata, note_valid, exp_pl[i]);
         end
      end
   endtask

   // Ramp back to env 15, release fully, then stay silent in IDLE.
   task automatic test_release();
      logic [7:0] exp_hold [6];
      logic [7:0] exp_dec [18];
      exp_hold = '{159, 87, 0, 104, 223, 119};
      exp_dec  = '{0, 120, 223, 103, 0, 88, 159, 71, 0, 56, 95, 39, 0, 24, 31, 7, 0, 0};
      for (int i = 0; i < 6; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_hold[i]) begin
            n_err++;
            $display("FAIL release_hold[%0d]: got md=%0d, want %0d", i, musicdata, exp_hold[i]);
         end
      end
      key_in = 8'h00;
      for (int i = 0; i < 18; i++) begin
         wait_tick();
         n_cmp++;
         if (musicdata !== exp_dec[i] || note_valid !== (i < 15)) begin
            n_err++;
            $display("FAIL release_dec[%0d]: got md=%0d nv=%b, want md=%0d nv=%b",
                     i, musicdata, note_valid, exp_dec[i], (i < 15));
         end
      end
   endtask

   initial begin
      test_reset();
      test_attack();
      test_retarget();
      test_reset_mid_note();
      test_tune_write();
      test_repress();
      test_release();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
